// File: rtl/axi_sram.sv
// axi_sram: AXI4-lite-style SRAM slave with independent read and write
// channel FSMs. Each channel answers after a fixed, parameterised latency.
// The backing store is a word-addressed array that reset never clears.
module axi_sram #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          READ_LAT    = 2,
  parameter int          WRITE_LAT   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] araddr_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rvalid_o,
  input  logic        rready_i,
  input  logic [31:0] awaddr_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  wstrb_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  output logic [1:0]  bresp_o,
  output logic        bvalid_o,
  input  logic        bready_i
);

  localparam int          IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  RD_CNT = 4'(READ_LAT - 1);
  localparam logic [3:0]  WR_CNT = 4'(WRITE_LAT - 1);
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rState_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wState_e;

  logic [31:0] mem [DEPTH_WORDS];

  rState_e     rState_q, rState_d;
  logic [31:0] rAddr_q, rAddr_d;
  logic [3:0]  rCnt_q, rCnt_d;
  logic [31:0] rData_q;
  logic [1:0]  rResp_q;
  logic        rSample;

  wState_e     wState_q, wState_d;
  logic [31:0] wAddr_q, wAddr_d;
  logic [31:0] wData_q, wData_d;
  logic [3:0]  wStrb_q, wStrb_d;
  logic        awDone_q, awDone_d;
  logic        wDone_q, wDone_d;
  logic [3:0]  wCnt_q, wCnt_d;
  logic [1:0]  bResp_q;
  logic        wCommit;

  // Offsets are formed in 33 bits so an address below the base borrows into
  // bit 32 and fails the span compare instead of wrapping into range.
  logic [32:0]      rOff, wOff;
  logic             rInRange, wInRange;
  logic [IDX_W-1:0] rIdx, wIdx;

  assign rOff     = {1'b0, rAddr_q} - {1'b0, ADDR_BASE};
  assign wOff     = {1'b0, wAddr_q} - {1'b0, ADDR_BASE};
  assign rInRange = (rOff < SPAN);
  assign wInRange = (wOff < SPAN);
  assign rIdx     = rOff[IDX_W+1:2];
  assign wIdx     = wOff[IDX_W+1:2];

  // The upper strobe lanes have no storage behind them.
  logic unusedStrb;
  assign unusedStrb = ^wstrb_i[7:4];

  // All outputs are forced low while reset is held, before the first edge too.
  assign arready_o = rst_i && (rState_q == R_IDLE);
  assign rvalid_o  = rst_i && (rState_q == R_RESP);
  assign rdata_o   = rst_i ? rData_q : '0;
  assign rresp_o   = rst_i ? rResp_q : '0;
  assign awready_o = rst_i && (wState_q == W_IDLE) && !awDone_q;
  assign wready_o  = rst_i && (wState_q == W_IDLE) && !wDone_q;
  assign bvalid_o  = rst_i && (wState_q == W_RESP);
  assign bresp_o   = rst_i ? bResp_q : '0;

  // Read channel next state: accept AR, count down the latency, then hold the response.
  always_comb begin
    rState_d = rState_q;
    rAddr_d  = rAddr_q;
    rCnt_d   = rCnt_q;
    rSample  = 1'b0;
    case (rState_q)
      R_IDLE: begin
        if (arvalid_i) begin
          rAddr_d  = araddr_i;
          rCnt_d   = RD_CNT;
          rState_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rCnt_q == 4'd0) begin
          rSample  = 1'b1;
          rState_d = R_RESP;
        end else begin
          rCnt_d = rCnt_q - 4'd1;
        end
      end
      R_RESP: begin
        if (rready_i) begin
          rState_d = R_IDLE;
        end
      end
      default: rState_d = R_IDLE;
    endcase
  end

  // Read channel state register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rState_q <= R_IDLE;
      rAddr_q  <= '0;
      rCnt_q   <= '0;
    end else begin
      rState_q <= rState_d;
      rAddr_q  <= rAddr_d;
      rCnt_q   <= rCnt_d;
    end
  end

  // Read data register; sampling with NBAs gives read-before-write on collisions.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rData_q <= '0;
      rResp_q <= OKAY;
    end else if (rSample) begin
      rData_q <= rInRange ? mem[rIdx] : '0;
      rResp_q <= rInRange ? OKAY : DECERR;
    end
  end

  // Write channel next state: collect AW and W in any order, wait, commit, then respond.
  always_comb begin
    wState_d = wState_q;
    wAddr_d  = wAddr_q;
    wData_d  = wData_q;
    wStrb_d  = wStrb_q;
    awDone_d = awDone_q;
    wDone_d  = wDone_q;
    wCnt_d   = wCnt_q;
    wCommit  = 1'b0;
    case (wState_q)
      W_IDLE: begin
        if (awvalid_i && !awDone_q) begin
          wAddr_d  = awaddr_i;
          awDone_d = 1'b1;
        end
        if (wvalid_i && !wDone_q) begin
          wData_d = wdata_i;
          wStrb_d = wstrb_i[3:0];
          wDone_d = 1'b1;
        end
        if (awDone_d && wDone_d) begin
          awDone_d = 1'b0;
          wDone_d  = 1'b0;
          wCnt_d   = WR_CNT;
          wState_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (wCnt_q == 4'd0) begin
          wCommit  = 1'b1;
          wState_d = W_RESP;
        end else begin
          wCnt_d = wCnt_q - 4'd1;
        end
      end
      W_RESP: begin
        if (bready_i) begin
          wState_d = W_IDLE;
        end
      end
      default: wState_d = W_IDLE;
    endcase
  end

  // Write channel state register and captured AW/W payload.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wState_q <= W_IDLE;
      wAddr_q  <= '0;
      wData_q  <= '0;
      wStrb_q  <= '0;
      awDone_q <= 1'b0;
      wDone_q  <= 1'b0;
      wCnt_q   <= '0;
      bResp_q  <= OKAY;
    end else begin
      wState_q <= wState_d;
      wAddr_q  <= wAddr_d;
      wData_q  <= wData_d;
      wStrb_q  <= wStrb_d;
      awDone_q <= awDone_d;
      wDone_q  <= wDone_d;
      wCnt_q   <= wCnt_d;
      if (wCommit) begin
        bResp_q <= wInRange ? OKAY : DECERR;
      end
    end
  end

  // Byte-lane memory write; a commit edge that sees reset asserted is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i && wCommit && wInRange) begin
      for (int i = 0; i < 4; i++) begin
        if (wStrb_q[i]) begin
          mem[wIdx][8*i +: 8] <= wData_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_sram.sv
// tb_axi_sram: self-checking bench for axi_sram with a behavioural memory model.
module tb_axi_sram;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          RLAT  = 2;
  localparam int          WLAT  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;

  int tests = 0;
  int fails = 0;

  logic [31:0] refMem [int];

  axi_sram #(
    .ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .READ_LAT(RLAT), .WRITE_LAT(WLAT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
    .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready),
    .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
    .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready)
  );

  always #5 clk = ~clk;

  // Watchdog so a hung handshake still ends the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "[TB] watchdog");
  end

  // Model: a byte address is valid iff it lies in [BASE, BASE + 4*DEPTH), no wrap.
  function automatic bit refInRange(input logic [31:0] a);
    longint unsigned la, lb;
    la = 64'(a);
    lb = 64'(BASE);
    return (la >= lb) && (la < lb + 64'(4 * DEPTH));
  endfunction

  function automatic int refIdx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic void refWrite(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
    logic [31:0] w;
    if (!refInRange(a)) return;
    w = refMem.exists(refIdx(a)) ? refMem[refIdx(a)] : 32'h0;
    for (int i = 0; i < 4; i++)
      if (s[i]) w[8*i +: 8] = d[8*i +: 8];
    refMem[refIdx(a)] = w;
  endfunction

  function automatic logic [31:0] refReadData(input logic [31:0] a);
    if (!refInRange(a)) return 32'h0;
    return refMem[refIdx(a)];
  endfunction

  function automatic logic [1:0] refResp(input logic [31:0] a);
    return refInRange(a) ? 2'b00 : 2'b11;
  endfunction

  function automatic logic [31:0] oorAddr();
    case ($urandom_range(0, 4))
      0: return BASE - 32'd4;
      1: return BASE + 32'(4 * DEPTH);
      2: return BASE + 32'(4 * DEPTH) + ($urandom & 32'h0FFF_FFFC);
      3: return 32'($urandom_range(0, 1000)) * 32'd4;
      default: return 32'hFFFF_FFFC;
    endcase
  endfunction

  // Read transaction; lat counts edges from the AR handshake edge to rvalid.
  task automatic axiRead(input logic [31:0] a, output logic [31:0] data,
                         output logic [1:0] resp, output int lat, output bit tout);
    bit hs;
    int c;
    tout = 0; lat = 0; c = 0; hs = 0; data = '0; resp = '0;
    @(negedge clk);
    araddr = a;
    arvalid = 1'b1;
    while (!hs && !tout) begin
      hs = arready;
      @(negedge clk);
      c++;
      if (c > 40) tout = 1;
    end
    arvalid = 1'b0;
    araddr = $urandom;
    while (!rvalid && !tout) begin
      @(negedge clk);
      lat++;
      if (lat > 40) tout = 1;
    end
    data = rdata;
    resp = rresp;
  endtask

  // Write transaction; AW and W start after awDel / wDel cycles respectively.
  task automatic axiWrite(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                          input int awDel, input int wDel,
                          output logic [1:0] resp, output int lat, output bit tout);
    bit awOk, wOk, hsAw, hsW;
    int c;
    awOk = 0; wOk = 0; tout = 0; lat = 0; c = 0; resp = '0;
    @(negedge clk);
    while (!(awOk && wOk) && !tout) begin
      if (!awOk && c >= awDel) begin awaddr = a; awvalid = 1'b1; end
      if (!wOk && c >= wDel) begin wdata = d; wstrb = s; wvalid = 1'b1; end
      hsAw = awvalid && awready;
      hsW  = wvalid && wready;
      @(negedge clk);
      c++;
      if (hsAw) begin awOk = 1; awvalid = 1'b0; awaddr = $urandom; end
      if (hsW) begin wOk = 1; wvalid = 1'b0; wdata = $urandom; wstrb = $urandom; end
      if (c > 40) tout = 1;
    end
    while (!bvalid && !tout) begin
      @(negedge clk);
      lat++;
      if (lat > 40) tout = 1;
    end
    resp = bresp;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (arready !== 1'b0) begin fails++; $display("[TB] FAIL reset_arready: got %b expected 0", arready); end
    tests++; if (awready !== 1'b0) begin fails++; $display("[TB] FAIL reset_awready: got %b expected 0", awready); end
    tests++; if (wready !== 1'b0) begin fails++; $display("[TB] FAIL reset_wready: got %b expected 0", wready); end
    tests++; if (rvalid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rvalid: got %b expected 0", rvalid); end
    tests++; if (bvalid !== 1'b0) begin fails++; $display("[TB] FAIL reset_bvalid: got %b expected 0", bvalid); end
    tests++; if (rdata !== 32'h0) begin fails++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
    tests++; if (rresp !== 2'b00) begin fails++; $display("[TB] FAIL reset_rresp: got %b expected 00", rresp); end
    tests++; if (bresp !== 2'b00) begin fails++; $display("[TB] FAIL reset_bresp: got %b expected 00", bresp); end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({arready, awready, wready} !== 3'b111) begin
      fails++; $display("[TB] FAIL reset_release_ready: got %b expected 111", {arready, awready, wready});
    end
  endtask

  task automatic test_basic();
    logic [31:0] d; logic [1:0] r; int lat; bit to;
    axiWrite(32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 0, 0, r, lat, to);
    refWrite(32'h8000_0010, 32'hDEAD_BEEF, 8'h0F);
    tests++; if (to || lat !== WLAT) begin fails++; $display("[TB] FAIL basic_wr_lat: got %0d (timeout %0d) expected %0d", lat, to, WLAT); end
    tests++; if (r !== 2'b00) begin fails++; $display("[TB] FAIL basic_bresp: got %b expected 00", r); end
    axiRead(32'h8000_0010, d, r, lat, to);
    tests++; if (to || lat !== RLAT) begin fails++; $display("[TB] FAIL basic_rd_lat: got %0d (timeout %0d) expected %0d", lat, to, RLAT); end
    tests++; if (d !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL basic_rdata: got %h expected deadbeef", d); end
    tests++; if (r !== 2'b00) begin fails++; $display("[TB] FAIL basic_rresp: got %b expected 00", r); end
  endtask

  task automatic test_partial();
    logic [31:0] d; logic [1:0] r; int lat; bit to;
    axiWrite(32'h8000_0010, 32'h1122_3344, 8'h06, 0, 0, r, lat, to);
    refWrite(32'h8000_0010, 32'h1122_3344, 8'h06);
    tests++; if (to || r !== 2'b00) begin fails++; $display("[TB] FAIL partial_bresp: got %b (timeout %0d) expected 00", r, to); end
    axiRead(32'h8000_0010, d, r, lat, to);
    tests++; if (d !== 32'hDE22_33EF) begin fails++; $display("[TB] FAIL partial_rdata: got %h expected de2233ef", d); end
    axiRead(32'h8000_0013, d, r, lat, to);
    tests++; if (d !== 32'hDE22_33EF) begin fails++; $display("[TB] FAIL partial_unaligned: got %h expected de2233ef", d); end
    // Upper strobe lanes carry no meaning: behaves like an empty strobe.
    axiWrite(32'h8000_0010, 32'hFFFF_FFFF, 8'hF0, 0, 0, r, lat, to);
    refWrite(32'h8000_0010, 32'hFFFF_FFFF, 8'hF0);
    tests++; if (to || r !== 2'b00) begin fails++; $display("[TB] FAIL nostrb_bresp: got %b (timeout %0d) expected 00", r, to); end
    axiRead(32'h8000_0010, d, r, lat, to);
    tests++; if (d !== refReadData(32'h8000_0010)) begin fails++; $display("[TB] FAIL nostrb_rdata: got %h expected %h", d, refReadData(32'h8000_0010)); end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d; logic [1:0] r; int lat; bit to;
    @(negedge clk);
    wdata = 32'hCAFE_F00D; wstrb = 8'h0F; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0; wdata = $urandom;
    tests++;
    if ({wready, awready} !== 2'b01) begin
      fails++; $display("[TB] FAIL wfirst_ready: got wready/awready %b expected 01", {wready, awready});
    end
    repeat (2) @(negedge clk);
    awaddr = 32'h8000_0040; awvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; awaddr = $urandom;
    refWrite(32'h8000_0040, 32'hCAFE_F00D, 8'h0F);
    lat = 0;
    while (!bvalid && lat <= 40) begin @(negedge clk); lat++; end
    tests++; if (lat !== WLAT) begin fails++; $display("[TB] FAIL wfirst_lat: got %0d expected %0d", lat, WLAT); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if ({bvalid, bresp, awready} !== 4'b1000) begin
        fails++; $display("[TB] FAIL bstall_hold: cycle %0d got bvalid/bresp/awready %b expected 1000", i, {bvalid, bresp, awready});
      end
    end
    bready = 1'b1;
    @(negedge clk);
    tests++; if (bvalid !== 1'b0) begin fails++; $display("[TB] FAIL bstall_release: got bvalid %b expected 0", bvalid); end
    axiRead(32'h8000_0040, d, r, lat, to);
    tests++; if (d !== 32'hCAFE_F00D) begin fails++; $display("[TB] FAIL wfirst_rdata: got %h expected cafef00d", d); end
  endtask

  task automatic test_read_stall();
    logic [31:0] d; logic [1:0] r; int lat; bit to;
    rready = 1'b0;
    axiRead(32'h8000_0040, d, r, lat, to);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if ({rvalid, arready, rdata} !== {2'b10, refReadData(32'h8000_0040)}) begin
        fails++; $display("[TB] FAIL rstall_hold: got rvalid/arready %b data %h expected 10 %h", {rvalid, arready}, rdata, refReadData(32'h8000_0040));
      end
    end
    rready = 1'b1;
    @(negedge clk);
    tests++; if (rvalid !== 1'b0) begin fails++; $display("[TB] FAIL rstall_release: got rvalid %b expected 0", rvalid); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] r; int lat; bit to;
    axiWrite(32'h8000_0000, 32'h1234_5678, 8'h0F, 0, 0, r, lat, to);
    refWrite(32'h8000_0000, 32'h1234_5678, 8'h0F);
    axiRead(32'h8000_4000, d, r, lat, to);
    tests++; if ({d, r} !== {32'h0, 2'b11}) begin fails++; $display("[TB] FAIL oor_read: got %h/%b expected 00000000/11", d, r); end
    axiWrite(32'h7FFF_FFFC, 32'hFFFF_FFFF, 8'h0F, 0, 0, r, lat, to);
    tests++; if (to || r !== 2'b11) begin fails++; $display("[TB] FAIL oor_bresp: got %b (timeout %0d) expected 11", r, to); end
    axiRead(32'h8000_0000, d, r, lat, to);
    tests++; if (d !== 32'h1234_5678) begin fails++; $display("[TB] FAIL oor_nowrite: got %h expected 12345678", d); end
    axiWrite(32'h8000_3FFC, 32'hA5A5_5A5A, 8'h0F, 0, 0, r, lat, to);
    refWrite(32'h8000_3FFC, 32'hA5A5_5A5A, 8'h0F);
    axiRead(32'h8000_3FFF, d, r, lat, to);
    tests++; if ({d, r} !== {32'hA5A5_5A5A, 2'b00}) begin fails++; $display("[TB] FAIL last_word: got %h/%b expected a5a55a5a/00", d, r); end
  endtask

  task automatic test_collision();
    logic [31:0] d; logic [1:0] rr, wr; int rl, wl; bit rto, wto;
    axiWrite(32'h8000_0020, 32'hAAAA_AAAA, 8'h0F, 0, 0, wr, wl, wto);
    refWrite(32'h8000_0020, 32'hAAAA_AAAA, 8'h0F);
    fork
      axiRead(32'h8000_0020, d, rr, rl, rto);
      axiWrite(32'h8000_0020, 32'h5555_5555, 8'h0F, 0, 0, wr, wl, wto);
    join
    tests++; if (rto || d !== 32'hAAAA_AAAA) begin fails++; $display("[TB] FAIL collide_old: got %h (timeout %0d) expected aaaaaaaa", d, rto); end
    refWrite(32'h8000_0020, 32'h5555_5555, 8'h0F);
    axiRead(32'h8000_0020, d, rr, rl, rto);
    tests++; if (d !== 32'h5555_5555) begin fails++; $display("[TB] FAIL collide_new: got %h expected 55555555", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; int lat; bit to; bit sawB;
    axiWrite(32'h8000_0030, 32'h0BAD_F00D, 8'h0F, 0, 0, r, lat, to);
    refWrite(32'h8000_0030, 32'h0BAD_F00D, 8'h0F);
    @(negedge clk);
    awaddr = 32'h8000_0030; awvalid = 1'b1;
    wdata = 32'hFFFF_FFFF; wstrb = 8'h0F; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    rst = 1'b0;
    sawB = 0;
    repeat (4) begin
      @(negedge clk);
      if (bvalid) sawB = 1;
    end
    tests++; if (sawB !== 1'b0) begin fails++; $display("[TB] FAIL midreset_bvalid: got bvalid during reset expected none"); end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({arready, awready, wready, bvalid} !== 4'b1110) begin
      fails++; $display("[TB] FAIL midreset_ready: got ar/aw/w/b %b expected 1110", {arready, awready, wready, bvalid});
    end
    axiRead(32'h8000_0030, d, r, lat, to);
    tests++; if (d !== 32'h0BAD_F00D) begin fails++; $display("[TB] FAIL midreset_mem: got %h expected 0badf00d", d); end
  endtask

  task automatic test_random();
    int widx[$];
    logic [31:0] a, d, got; logic [7:0] s; logic [1:0] r; int lat, idx; bit to;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 0 || widx.size() == 0) begin
        if ($urandom_range(0, 5) == 0) a = oorAddr();
        else a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd4 + 32'($urandom_range(0, 3));
        d = $urandom;
        s = 8'($urandom);
        if (refInRange(a) && !refMem.exists(refIdx(a))) begin
          s[3:0] = 4'hF;
          widx.push_back(refIdx(a));
        end
        axiWrite(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), r, lat, to);
        refWrite(a, d, s);
        tests++;
        if (to || lat !== WLAT || r !== refResp(a)) begin
          fails++; $display("[TB] FAIL rand_write: addr %h got lat %0d resp %b (timeout %0d) expected lat %0d resp %b", a, lat, r, to, WLAT, refResp(a));
        end
      end else begin
        if ($urandom_range(0, 4) == 0) a = oorAddr();
        else begin
          idx = widx[$urandom_range(0, widx.size() - 1)];
          a = BASE + 32'(idx) * 32'd4 + 32'($urandom_range(0, 3));
        end
        axiRead(a, got, r, lat, to);
        tests++;
        if (to || lat !== RLAT || got !== refReadData(a) || r !== refResp(a)) begin
          fails++; $display("[TB] FAIL rand_read: addr %h got %h/%b lat %0d (timeout %0d) expected %h/%b lat %0d", a, got, r, lat, to, refReadData(a), refResp(a), RLAT);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_w_before_aw();
    test_read_stall();
    test_out_of_range();
    test_collision();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
